// File: rtl/skid_pkg.sv
// ============================================================================
// Module      : skid_pkg
// Description : Shared helpers for the skid buffer family: ceiling log2 and
//               the counter/pointer width helpers built on it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package skid_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return clog2(depth + 1);
    endfunction

    // Width of a pointer into an array of 'entries' words; never below 1 bit.
    function automatic int ptr_width(input int entries);
        return (entries > 1) ? clog2(entries) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/skid_fifo_ring.sv
// ============================================================================
// Module      : skid_fifo_ring
// Description : Ordered storage ring behind the skid_fifo output register.
//               Pointers wrap explicitly, so ENTRIES need not be a power of 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_fifo_ring
    import skid_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty
);

    localparam int              PW       = ptr_width(ENTRIES);
    localparam int              CW       = count_width(ENTRIES);
    localparam logic [PW-1:0]   LAST_PTR = PW'(ENTRIES - 1);

    logic [DATA_WIDTH-1:0] mem [ENTRIES];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         entries;

    // Storage array: data only, contents are meaningless until counted in.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and entry count; pointers wrap from the last slot back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            entries <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   entries <= entries + CW'(1);
                2'b01:   entries <= entries - CW'(1);
                default: entries <= entries;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (entries == '0);

endmodule

`default_nettype wire

// File: rtl/skid_fifo.sv
// ============================================================================
// Module      : skid_fifo
// Description : Elastic valid/ready buffer of DEPTH words: a registered output
//               stage fed by a DEPTH-1 entry ring, with registered up_rdy so
//               dn_rdy never reaches up_rdy combinationally.
//               Optional macro SKID_FIFO_STATUS_EN adds count/almost_full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_fifo
    import skid_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4
`ifdef SKID_FIFO_STATUS_EN
   ,parameter int AFULL_LEVEL = DEPTH - 1
`endif
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              up_bus,
    input  logic                               up_val,
    output logic                               up_rdy,
    output logic [DATA_WIDTH-1:0]              dn_bus,
    output logic                               dn_val,
    input  logic                               dn_rdy
`ifdef SKID_FIFO_STATUS_EN
   ,output logic [count_width(DEPTH)-1:0]      count,
    output logic                               almost_full
`endif
);

    localparam int CW = count_width(DEPTH);

    logic                  push;
    logic                  pop;
    logic                  load_en;
    logic                  ring_push;
    logic                  ring_pop;
    logic                  ring_empty;
    logic [DATA_WIDTH-1:0] ring_rdata;
    logic [CW-1:0]         occ;
    logic [CW-1:0]         occ_next;

    assign push    = up_val & up_rdy;
    assign pop     = dn_val & dn_rdy;
    assign load_en = ~dn_val | dn_rdy;

    // The ring head always wins the output register; a push only bypasses
    // the ring when the ring is empty and the output register is loadable.
    assign ring_pop  = load_en & ~ring_empty;
    assign ring_push = push & ~(load_en & ring_empty);

    skid_fifo_ring #(
        .DATA_WIDTH (DATA_WIDTH),
        .ENTRIES    (DEPTH - 1)
    ) u_ring (
        .clk   (clk),
        .rst   (rst),
        .push  (ring_push),
        .wdata (up_bus),
        .pop   (ring_pop),
        .rdata (ring_rdata),
        .empty (ring_empty)
    );

    // Occupancy after this cycle's push and pop.
    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + CW'(1);
            2'b01:   occ_next = occ - CW'(1);
            default: occ_next = occ;
        endcase
    end

    // Output register: ring head first, then direct bypass, else go idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_val <= 1'b0;
            dn_bus <= '0;
        end else if (load_en) begin
            if (!ring_empty) begin
                dn_val <= 1'b1;
                dn_bus <= ring_rdata;
            end else if (push) begin
                dn_val <= 1'b1;
                dn_bus <= up_bus;
            end else begin
                dn_val <= 1'b0;
            end
        end
    end

    // Occupancy and ready registers; ready reflects room after this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ    <= '0;
            up_rdy <= 1'b0;
        end else begin
            occ    <= occ_next;
            up_rdy <= (occ_next < CW'(DEPTH));
        end
    end

`ifdef SKID_FIFO_STATUS_EN
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_afull_check
        $error("skid_fifo: AFULL_LEVEL out of range 1..DEPTH");
    end

    // Almost-full flag tracks the same occupancy update as up_rdy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (occ_next >= CW'(AFULL_LEVEL));
        end
    end

    assign count = occ;
`endif

endmodule

`default_nettype wire

// File: doc/skid_fifo.md
# skid_fifo

Parametrised elastic buffer for valid/ready streams. It replaces the single-entry skid register wherever a pipeline stage needs more than one cycle of slack. It holds up to DEPTH words in order, with fully registered outputs and a registered up_rdy, so no combinational path runs from dn_rdy to up_rdy. It sits between any two valid/ready pipeline stages and is the default register-slice and rate-decoupling element for new datapaths.

## Interface
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 4, total capacity in words including the output register; legal values are 2 or more.
- AFULL_LEVEL, DEPTH-1, almost-full threshold in words; used only when SKID_FIFO_STATUS_EN is defined.

Ports (clock and reset first):
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- up_bus  input  DATA_WIDTH  upstream payload.
- up_val  input  1  upstream valid.
- up_rdy  output  1  upstream ready, registered.
- dn_bus  output  DATA_WIDTH  downstream payload, registered.
- dn_val  output  1  downstream valid, registered.
- dn_rdy  input  1  downstream ready.
- count  output  clog2(DEPTH+1)  occupancy, registered; present only with SKID_FIFO_STATUS_EN.
- almost_full  output  1  high when count >= AFULL_LEVEL, registered; present only with SKID_FIFO_STATUS_EN.

## Operation
- Push: up_val & up_rdy at a clock edge. Pop: dn_val & dn_rdy at a clock edge.
- Storage consists of the output register (dn_bus/dn_val) plus a ring of DEPTH-1 entries.
- Occupancy equals dn_val plus the number of ring entries.
- Output register update condition: load_en = ~dn_val | dn_rdy. When load_en is high, in priority order:
  - If the ring is non-empty, load the ring head.
  - Otherwise, if there is a push, load up_bus directly.
  - Otherwise, clear dn_val.
  - When load_en is low, dn_bus and dn_val hold.
- A push that does not go straight to the output register is written at the ring tail.
- Ordering is strictly FIFO. Data never bypasses older ring entries.
- Ring read/write pointers wrap explicitly from DEPTH-2 to 0, so DEPTH-1 need not be a power of two.
- DEPTH=2 gives a one-entry ring, which behaves as a skid register with asynchronous reset.
- Registered ready: up_rdy at the next edge is (occ_next < DEPTH), where occ_next is the occupancy after the current push and pop. A push can therefore never overflow, and no extra slack entry is needed.
- Pushes attempted while up_rdy is low are ignored. Pops attempted while dn_val is low are ignored.

## Timing
- Reset values, applied immediately on rst assertion without waiting for a clock edge:
  - up_rdy=0, dn_val=0, dn_bus=0.
  - Ring pointers=0, count=0, almost_full=0.
- First rising edge after rst deasserts: up_rdy goes to 1.
- Latency: a push at edge N into an empty buffer appears on dn_bus/dn_val after edge N.
- Throughput: one word per cycle sustained while dn_rdy=1, with no bubbles.
- Backpressure: up_rdy falls after the edge at which the DEPTH-th word is accepted without a pop.
- Recovery: up_rdy rises after the first edge at which a pop occurs with no push.
- Simultaneous push and pop: occupancy is unchanged, and up_rdy is unchanged unless occupancy is DEPTH.
- Mid-operation reset: all contents are discarded asynchronously. No stale word may reach dn_val=1 after reset.
- dn_val and dn_bus must not change while dn_val=1 and dn_rdy=0.

## Configuration
- SKID_FIFO_STATUS_EN defined:
  - The count and almost_full ports exist.
  - Both outputs are registered and updated from occ_next on the same edge as up_rdy.
  - AFULL_LEVEL is range-checked by elaboration assertion to 1..DEPTH.
- SKID_FIFO_STATUS_EN undefined:
  - Neither port exists. The occupancy counter is still kept internally to drive up_rdy.
  - Handshake behaviour and timing are identical to the defined case.

## Structure
- Shared package skid_pkg holds:
  - The clog2 constant function.
  - Any count-width localparam helpers used by this block and future skid variants.
- Sub-module skid_fifo_ring is natural. It contains:
  - The DEPTH-1 entry storage array.
  - Read/write pointers with explicit wrap.
  - The entry count, with push/pop/empty ports.
- The top level holds the output register, the load/bypass mux, the occupancy logic and the ready register.

## Test plan
- Reset: hold rst for 3 cycles with random inputs → all outputs 0. Release → up_rdy=1 one edge later, dn_val=0.
- Streaming: DEPTH=4, dn_rdy=1, push 0x01..0x10 back-to-back → dn_bus shows 0x01..0x10 one cycle after each push, no gaps, count stays 1.
- Fill and drain: DEPTH=4, dn_rdy=0, push A,B,C,D → up_rdy=0 after 4th push, count=4. Then dn_rdy=1 → A,B,C,D in order, up_rdy=1 after the first pop.
- Simultaneous events: count=3, push E and pop on the same edge → count stays 3, up_rdy stays 1, E emerges after the remaining older words.
- Wrap and DEPTH=2/5 sweep: 200 words with random up_val and dn_rdy → scoreboard shows exact order, no loss or duplication, count always matches the scoreboard.
- Mid-operation reset: assert rst asynchronously between edges with count=3 → dn_val and up_rdy drop immediately. After release, the first dn_val=1 carries only newly pushed data.
